// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and sizing constants for the SPI slave.
package spi_pkg;
    localparam int SPI_BITS = 8;
    localparam int SYNC_STAGES = 2;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: 4-entry rx byte FIFO with wrap-around pointers and occupancy count.
module spi_rx_fifo
    import spi_pkg::*;
(
    input  logic                Clk_i,
    input  logic                Rst_ni,
    input  logic                push,
    input  logic [SPI_BITS-1:0] push_data,
    input  logic                pop,
    output logic                full,
    output logic                valid,
    output logic [SPI_BITS-1:0] data
);
    logic [SPI_BITS-1:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic do_push, do_pop;

    assign full    = count == 3'd4;
    assign valid   = count != 3'd0;
    assign data    = mem[rd_ptr];
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_push = push && (!full || pop);

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, do_push} - {2'b0, do_pop};
        end
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave, MSB first, with tx/rx byte handshakes on Clk_i.
// Define SPI_SLAVE_RX_FIFO_EN for a 4-entry rx FIFO instead of a single rx register.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [1:0]          SLAVE_ID  = 2'd1,
    parameter logic [SPI_BITS-1:0] IDLE_BYTE = 8'hFF
) (
    input  logic                Clk_i,
    input  logic                Rst_ni,
    input  logic                sck_i,
    input  logic [1:0]          ss_i,
    input  logic                mosi_i,
    output logic                miso_o,
    input  logic [SPI_BITS-1:0] tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic [SPI_BITS-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                overrun_o,
    output logic                underrun_o
);
    logic [SYNC_STAGES-1:0]      sck_sync, mosi_sync, warm;
    logic [SYNC_STAGES-1:0][1:0] ss_sync;
    logic                        sck_d, armed, hold_full, drop;
    state_t                      state;
    logic [2:0]                  bit_cnt;
    logic [SPI_BITS-1:0]         rx_shift, tx_shift, hold, rx_byte;
    logic                        sck, mosi, sel, start, rise, fall, done, load;

    assign sck     = sck_sync[SYNC_STAGES-1];
    assign mosi    = mosi_sync[SYNC_STAGES-1];
    assign sel     = ss_sync[SYNC_STAGES-1] == SLAVE_ID;
    // Only enter ACTIVE after a deselect has been observed, so a reset mid-transfer cannot resume it.
    assign start   = state == IDLE && armed && sel;
    assign rise    = state == ACTIVE && sel && sck && !sck_d;
    assign fall    = state == ACTIVE && sel && !sck && sck_d;
    assign done    = rise && bit_cnt == 3'd7;
    assign load    = start || done;
    assign rx_byte = {rx_shift[SPI_BITS-2:0], mosi};
    assign miso_o  = state == ACTIVE && tx_shift[SPI_BITS-1];
    assign tx_ready_o = !hold_full;

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            sck_sync   <= '0;
            mosi_sync  <= '0;
            ss_sync    <= '0;
            warm       <= '0;
            sck_d      <= 1'b0;
            armed      <= 1'b0;
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            overrun_o  <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            ss_sync    <= {ss_sync[SYNC_STAGES-2:0], ss_i};
            warm       <= {warm[SYNC_STAGES-2:0], 1'b1};
            sck_d      <= sck;
            armed      <= armed || (warm[SYNC_STAGES-1] && !sel);
            overrun_o  <= done && drop;
            underrun_o <= load && !hold_full;
            if (load) begin
                tx_shift  <= hold_full ? hold : IDLE_BYTE;
                hold_full <= 1'b0;
            end else if (fall && bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[SPI_BITS-2:0], 1'b0};
            end
            // Written after the load so an empty-register write lands behind the byte just loaded.
            if (tx_valid_i && !hold_full) begin
                hold      <= tx_data_i;
                hold_full <= 1'b1;
            end
            if (state == IDLE) begin
                if (start) begin
                    state   <= ACTIVE;
                    bit_cnt <= '0;
                end
            end else if (!sel) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte;
            end
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    logic rx_full;

    assign drop = rx_full && !rx_ready_i;

    spi_rx_fifo u_rx_fifo (
        .Clk_i     (Clk_i),
        .Rst_ni    (Rst_ni),
        .push      (done),
        .push_data (rx_byte),
        .pop       (rx_ready_i),
        .full      (rx_full),
        .valid     (rx_valid_o),
        .data      (rx_data_o)
    );
`else
    assign drop = rx_valid_o && !rx_ready_i;

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
        end else if (done && !drop) begin
            rx_valid_o <= 1'b1;
            rx_data_o  <= rx_byte;
        end else if (rx_ready_i) begin
            rx_valid_o <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives a mode-0 SPI master and checks against a byte-level model.
module tb_spi_slave;
    localparam logic [1:0] ID = 2'd1;
    localparam int HALF = 6;
`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic sck = 1'b0, mosi = 1'b0, miso;
    logic [1:0] ss = 2'd0;
    logic [7:0] tx_data = '0, rx_data;
    logic tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0, overrun, underrun;

    always #5 clk = ~clk;

    spi_slave dut (
        .Clk_i      (clk),
        .Rst_ni     (rst_n),
        .sck_i      (sck),
        .ss_i       (ss),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .overrun_o  (overrun),
        .underrun_o (underrun)
    );

    int checks = 0, errors = 0;
    int ov_seen = 0, un_seen = 0;
    bit m_hold_full = 0, live = 0;
    logic [7:0] m_hold = '0, exp_tx = '0;
    logic [7:0] rxq[$];
    int m_ov = 0, m_un = 0;

    always @(negedge clk) if (rst_n) begin
        if (overrun) ov_seen++;
        if (underrun) un_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] m_load();
        if (m_hold_full) begin
            m_hold_full = 0;
            return m_hold;
        end
        m_un++;
        return 8'hFF;
    endfunction

    task automatic tx_write(input logic [7:0] b);
        check("tx_ready", tx_ready, !m_hold_full);
        if (!m_hold_full) begin
            tx_data = b;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            m_hold = b;
            m_hold_full = 1;
        end
    endtask

    task automatic select();
        ss = ID;
        tick(6);
        live = 1;
        exp_tx = m_load();
    endtask

    task automatic deselect(input logic [1:0] v);
        ss = v;
        tick(6);
        live = 0;
    endtask

    task automatic frame(input logic [7:0] mo, input int nbits, input bit wr, input logic [7:0] wb);
        logic [7:0] mi;
        mi = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = mo[i];
            tick(HALF);
            mi[i] = miso;
            sck = 1'b1;
            tick(HALF);
            if (wr && i == 4) tx_write(wb);
            sck = 1'b0;
        end
        tick(HALF);
        if (nbits == 8) begin
            check("miso_byte", mi, live ? exp_tx : 8'h00);
            if (live) begin
                if (rxq.size() < CAP) rxq.push_back(mo);
                else m_ov++;
                exp_tx = m_load();
            end
        end
        check("rx_valid", rx_valid, rxq.size() > 0);
        if (rxq.size() > 0) check("rx_data", rx_data, rxq[0]);
        check("underruns", un_seen, m_un);
        check("overruns", ov_seen, m_ov);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            check("rx_valid", rx_valid, rxq.size() > 0);
            if (rxq.size() == 0) break;
            check("rx_data", rx_data, rxq[0]);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            void'(rxq.pop_front());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        check("rst_miso", miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_underrun", underrun, 0);
        rst_n = 1'b1;
        m_hold_full = 0;
        rxq.delete();
        live = 0;
        tick(4);
    endtask

    initial begin
        int u0, o0;
        do_reset();
        // select, A5 in, preloaded 3C out, next tx queued mid-byte so nothing underruns
        tx_write(8'h3C);
        select();
        frame(8'hA5, 8, 1, 8'($urandom));
        check("a5_no_underrun", un_seen, 0);
        drain(1);
        // back-to-back bytes without deselect
        deselect(2'd0);
        tx_write(8'h11);
        select();
        frame(8'h01, 8, 1, 8'h22);
        drain(1);
        frame(8'h80, 8, 0, 8'h00);
        drain(1);
        // empty tx: idle byte out, exactly one underrun
        deselect(2'd0);
        u0 = un_seen;
        select();
        frame(8'($urandom), 8, 1, 8'h77);
        check("underrun_once", un_seen - u0, 1);
        drain(1);
        // rx held off past capacity
        o0 = ov_seen;
        for (int f = 0; f <= CAP; f++) frame(8'($urandom), 8, 1, 8'($urandom));
        check("overrun_once", ov_seen - o0, 1);
        drain(CAP + 1);
        // partial byte discarded by deselect
        frame(8'($urandom), 4, 0, 8'h00);
        deselect(2'd0);
        select();
        frame(8'h5A, 8, 0, 8'h00);
        check("after_partial", rx_data, 8'h5A);
        drain(2);
        // other slave addressed
        deselect(2'd2);
        frame(8'($urandom), 8, 0, 8'h00);
        // reset mid-transfer with ss held: must stay idle until reselected
        select();
        frame(8'($urandom), 3, 0, 8'h00);
        do_reset();
        frame(8'($urandom), 8, 0, 8'h00);
        deselect(2'd0);
        select();
        frame(8'hC3, 8, 1, 8'($urandom));
        drain(1);
        for (int r = 0; r < 40; r++) begin
            frame(8'($urandom), 8, bit'($urandom_range(0, 1)), 8'($urandom));
            drain($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) begin
                deselect(2'd0);
                select();
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
